fir_coeff_loader: RTL and testbench

//   Coefficient-write master for fir_transpose. Accepts a valid/ready stream of NUM_TAPS

---
 rtl/fir_coeff_loader.sv | 210 +++++++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient-write master for fir_transpose: streams NUM_TAPS taps into the filter's
// load port, then optionally reads them back and reports the first mismatching address.
module fir_coeff_loader #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 8,
  parameter int NUM_TAPS = 16,
  parameter int VERIFY   = 1,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Hlt,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              load,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_value,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO_C = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE_C = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  generate
    if (NUM_TAPS < 1 || NUM_TAPS > (1 << ADDR_W) || READ_LAT < 0 || READ_LAT > 1) begin : g_param_err
      $error("fir_coeff_loader: NUM_TAPS must be 1..2**ADDR_W and READ_LAT 0 or 1");
    end
  endgenerate

  state_t              state_r;
  state_t              next_state_s;
  logic                s_ready_s;
  logic                load_s;
  logic                busy_s;
  logic                done_s;
  logic [ADDR_W-1:0]   tap_cnt_r;
  logic [DATA_W-1:0]   shadow_r [2**IDX_W];
  logic                rd_issue_r;
  logic                cmp_vld_s;
  logic [ADDR_W-1:0]   cmp_addr_s;
  logic [DATA_W-1:0]   shadow_rd_s;
  logic                mismatch_s;
  logic                start_acc_s;
  logic                beat_s;

  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign beat_s      = s_valid && s_ready;

  // State register; the handshake/status outputs are registered from the next state.
  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      state_r <= ST_IDLE;
      s_ready <= 1'b0;
      load    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      s_ready <= s_ready_s;
      load    <= load_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

  // Next-state decode; LOAD and VERIFY both end on the terminal count, never by wrapping.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_LOAD;
        else       next_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (beat_s && (tap_cnt_r == LAST_C)) next_state_s = ST_COMMIT;
        else                                 next_state_s = ST_LOAD;
      end
      ST_COMMIT: begin
        if (VERIFY != 0) next_state_s = ST_VERIFY;
        else             next_state_s = ST_DONE;
      end
      ST_VERIFY: begin
        if (cmp_vld_s && (cmp_addr_s == LAST_C)) next_state_s = ST_DONE;
        else                                     next_state_s = ST_VERIFY;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the state being entered.
  always_comb begin
    s_ready_s = 1'b0;
    load_s    = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (next_state_s)
      ST_LOAD: begin
        s_ready_s = 1'b1;
        load_s    = 1'b1;
        busy_s    = 1'b1;
      end
      ST_COMMIT: begin
        load_s = 1'b1;
        busy_s = 1'b1;
      end
      ST_VERIFY: busy_s = 1'b1;
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        s_ready_s = 1'b0;
        load_s    = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
      end
    endcase
  end

  // Tap counter and FIR write port; a stalled stream simply holds the last address/value.
  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      tap_cnt_r     <= ADDR_ZERO_C;
      write_address <= ADDR_ZERO_C;
      write_value   <= {DATA_W{1'b0}};
    end else if (start_acc_s) begin
      tap_cnt_r <= ADDR_ZERO_C;
    end else if (beat_s) begin
      write_address <= tap_cnt_r;
      write_value   <= s_data;
      if (tap_cnt_r != LAST_C) tap_cnt_r <= tap_cnt_r + ADDR_ONE_C;
    end
  end

  // Shadow copy of every accepted tap for the readback compare.
  always_ff @(posedge Clk) begin
    if (beat_s) shadow_r[tap_cnt_r[IDX_W-1:0]] <= s_data;
  end

  // Readback address issue: one address per cycle from 0 to the last tap.
  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      read_address <= ADDR_ZERO_C;
      rd_issue_r   <= 1'b0;
    end else if ((state_r == ST_COMMIT) && (next_state_s == ST_VERIFY)) begin
      read_address <= ADDR_ZERO_C;
      rd_issue_r   <= 1'b1;
    end else if (rd_issue_r) begin
      if (read_address == LAST_C) rd_issue_r <= 1'b0;
      else                        read_address <= read_address + ADDR_ONE_C;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_lat0
      assign cmp_vld_s  = rd_issue_r;
      assign cmp_addr_s = read_address;
    end else begin : g_lat1
      logic              cmp_vld_r;
      logic [ADDR_W-1:0] cmp_addr_r;
      // Delay the issued address to line up with the FIR's registered read data.
      always_ff @(posedge Clk or posedge Hlt) begin
        if (Hlt) begin
          cmp_vld_r  <= 1'b0;
          cmp_addr_r <= ADDR_ZERO_C;
        end else begin
          cmp_vld_r  <= rd_issue_r;
          cmp_addr_r <= read_address;
        end
      end
      assign cmp_vld_s  = cmp_vld_r;
      assign cmp_addr_s = cmp_addr_r;
    end
  endgenerate

  assign shadow_rd_s = shadow_r[cmp_addr_s[IDX_W-1:0]];
  assign mismatch_s  = cmp_vld_s && (read_value != shadow_rd_s);

  // Sticky error keeps the first failing address until the next accepted start.
  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      error    <= 1'b0;
      err_addr <= ADDR_ZERO_C;
    end else if (start_acc_s) begin
      error    <= 1'b0;
      err_addr <= ADDR_ZERO_C;
    end else if (mismatch_s && !error) begin
      error    <= 1'b1;
      err_addr <= cmp_addr_s;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a 16-tap FIR register-file model with one-cycle
// readback, plus a second loader instance with VERIFY=0 and a single tap.
module tb_fir_coeff_loader;

  logic        Clk;
  logic        Hlt;
  logic        start, s_valid, s_ready, load, busy, done, error;
  logic [11:0] s_data, write_value, read_value;
  logic [7:0]  write_address, read_address, err_addr;
  logic        start1, s_valid1, s_ready1, load1, busy1, done1, error1;
  logic [11:0] s_data1, wv1;
  logic [7:0]  wa1, ra1, ea1;

  int n_checks = 0;
  int n_fail = 0;

  logic [11:0] fir_mem [16];
  logic [11:0] taps [16];
  logic        corrupt_en;
  int          c_done, n_load, n_done;
  logic [7:0]  wa_log [64];
  logic        ready_log [64];
  logic        ab_load, ab_busy, ab_ready;
  logic [7:0]  ab_wa;
  logic [11:0] old6;

  fir_coeff_loader #(.DATA_W(12), .ADDR_W(8), .NUM_TAPS(16), .VERIFY(1), .READ_LAT(1)) u_dut (
    .Clk(Clk), .Hlt(Hlt), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .load(load), .write_address(write_address), .write_value(write_value),
    .read_address(read_address), .read_value(read_value), .busy(busy), .done(done),
    .error(error), .err_addr(err_addr)
  );

  fir_coeff_loader #(.DATA_W(12), .ADDR_W(8), .NUM_TAPS(1), .VERIFY(0), .READ_LAT(1)) u_dut1 (
    .Clk(Clk), .Hlt(Hlt), .start(start1), .s_valid(s_valid1), .s_data(s_data1),
    .s_ready(s_ready1), .load(load1), .write_address(wa1), .write_value(wv1),
    .read_address(ra1), .read_value(12'h000), .busy(busy1), .done(done1),
    .error(error1), .err_addr(ea1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // FIR coefficient store: captures on load, registered readback with optional corruption.
  always @(posedge Clk) begin
    if (load) fir_mem[write_address[3:0]] <= write_value;
    if (corrupt_en && read_address == 8'd7)      read_value <= 12'h0AA;
    else if (corrupt_en && read_address == 8'd9) read_value <= 12'h055;
    else                                         read_value <= fir_mem[read_address[3:0]];
  end

  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run_seq(input int stall_beat, input int stall_len, input int poke_a,
                         input int poke_b, input int abort_beat);
    int beat;
    int stall_left;
    logic hs;
    beat = 0; stall_left = stall_len; c_done = 0; n_load = 0; n_done = 0;
    for (int i = 0; i < 64; i++) begin wa_log[i] = 8'h00; ready_log[i] = 1'b0; end
    @(posedge Clk); #1;
    start = 1'b1; s_valid = 1'b1; s_data = taps[0];
    @(posedge Clk); #1;
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (c < 64) begin wa_log[c] = write_address; ready_log[c] = s_ready; end
      if (load) n_load++;
      if (done) begin n_done++; if (c_done == 0) c_done = c; end
      if (c_done != 0 && c > c_done + 3) break;
      if (beat == stall_beat && stall_left > 0) begin s_valid = 1'b0; stall_left--; end
      else s_valid = (beat < 16);
      s_data = taps[beat < 16 ? beat : 15];
      start = (c == poke_a || c == poke_b);
      hs = s_valid && s_ready;
      @(posedge Clk); #1;
      if (hs) beat++;
      if (abort_beat >= 0 && beat == abort_beat) begin
        Hlt = 1'b1; #1;
        ab_load = load; ab_busy = busy; ab_ready = s_ready; ab_wa = write_address;
        start = 1'b0; s_valid = 1'b0;
        return;
      end
    end
    start = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset();
    Hlt = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 12'h000; corrupt_en = 1'b0;
    start1 = 1'b0; s_valid1 = 1'b0; s_data1 = 12'h000;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %0b expected 0", s_ready); end
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %0b expected 0", load); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", done); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %0b expected 0", error); end
    n_checks++; if (write_address !== 8'h00) begin n_fail++; $display("FAIL rst_wa: got %0h expected 0", write_address); end
    n_checks++; if (write_value !== 12'h000) begin n_fail++; $display("FAIL rst_wv: got %0h expected 0", write_value); end
    n_checks++; if (read_address !== 8'h00) begin n_fail++; $display("FAIL rst_ra: got %0h expected 0", read_address); end
    n_checks++; if (err_addr !== 8'h00) begin n_fail++; $display("FAIL rst_err_addr: got %0h expected 0", err_addr); end
    Hlt = 1'b0;
    @(posedge Clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) taps[k] = 12'(k + 1);
    run_seq(-1, 0, -1, -1, -1);
    n_checks++; if (c_done !== 35) begin n_fail++; $display("FAIL t1_done_cycle: got %0d expected 35", c_done); end
    n_checks++; if (n_load !== 17) begin n_fail++; $display("FAIL t1_load_cycles: got %0d expected 17", n_load); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL t1_done_pulses: got %0d expected 1", n_done); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL t1_error: got %0b expected 0", error); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_end: got %0b expected 0", busy); end
    for (int c = 2; c <= 17; c++) begin
      n_checks++; if (wa_log[c] !== 8'(c - 2)) begin n_fail++; $display("FAIL t1_wa_cycle%0d: got %0h expected %0h", c, wa_log[c], c - 2); end
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (fir_mem[k] !== taps[k]) begin n_fail++; $display("FAIL t1_fir_tap%0d: got %0h expected %0h", k, fir_mem[k], taps[k]); end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 16; k++) taps[k] = 12'h100 + 12'(k);
    run_seq(5, 3, -1, -1, -1);
    n_checks++; if (c_done !== 38) begin n_fail++; $display("FAIL t2_done_cycle: got %0d expected 38", c_done); end
    n_checks++; if (n_load !== 20) begin n_fail++; $display("FAIL t2_load_cycles: got %0d expected 20", n_load); end
    for (int c = 6; c <= 9; c++) begin
      n_checks++; if (wa_log[c] !== 8'd4) begin n_fail++; $display("FAIL t2_wa_hold_cycle%0d: got %0h expected 4", c, wa_log[c]); end
    end
    for (int c = 6; c <= 8; c++) begin
      n_checks++; if (ready_log[c] !== 1'b1) begin n_fail++; $display("FAIL t2_ready_cycle%0d: got %0b expected 1", c, ready_log[c]); end
    end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL t2_error: got %0b expected 0", error); end
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (fir_mem[k] !== taps[k]) begin n_fail++; $display("FAIL t2_fir_tap%0d: got %0h expected %0h", k, fir_mem[k], taps[k]); end
    end
  endtask

  task automatic test_corrupt();
    for (int k = 0; k < 16; k++) taps[k] = 12'(k);
    corrupt_en = 1'b1;
    run_seq(-1, 0, -1, -1, -1);
    corrupt_en = 1'b0;
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL t3_error: got %0b expected 1", error); end
    n_checks++; if (err_addr !== 8'd7) begin n_fail++; $display("FAIL t3_err_addr: got %0h expected 7", err_addr); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL t3_done_pulses: got %0d expected 1", n_done); end
    n_checks++; if (c_done !== 35) begin n_fail++; $display("FAIL t3_done_cycle: got %0d expected 35", c_done); end
    repeat (3) @(posedge Clk);
    #1;
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL t3_error_sticky: got %0b expected 1", error); end
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 16; k++) taps[k] = 12'h200 + 12'(k);
    run_seq(-1, 0, 25, 35, -1);
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL t5_done_pulses: got %0d expected 1", n_done); end
    n_checks++; if (n_load !== 17) begin n_fail++; $display("FAIL t5_load_cycles: got %0d expected 17", n_load); end
    n_checks++; if (c_done !== 35) begin n_fail++; $display("FAIL t5_done_cycle: got %0d expected 35", c_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy_end: got %0b expected 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL t5_error_cleared: got %0b expected 0", error); end
  endtask

  task automatic test_abort();
    old6 = fir_mem[6];
    for (int k = 0; k < 16; k++) taps[k] = 12'h300 + 12'(k);
    run_seq(-1, 0, -1, -1, 7);
    n_checks++; if (ab_load !== 1'b0) begin n_fail++; $display("FAIL t4_abort_load: got %0b expected 0", ab_load); end
    n_checks++; if (ab_busy !== 1'b0) begin n_fail++; $display("FAIL t4_abort_busy: got %0b expected 0", ab_busy); end
    n_checks++; if (ab_ready !== 1'b0) begin n_fail++; $display("FAIL t4_abort_ready: got %0b expected 0", ab_ready); end
    n_checks++; if (ab_wa !== 8'h00) begin n_fail++; $display("FAIL t4_abort_wa: got %0h expected 0", ab_wa); end
    #2 Hlt = 1'b0;
    n_checks++; if (fir_mem[5] !== 12'h305) begin n_fail++; $display("FAIL t4_partial_tap5: got %0h expected 305", fir_mem[5]); end
    n_checks++; if (fir_mem[6] !== old6) begin n_fail++; $display("FAIL t4_partial_tap6: got %0h expected %0h", fir_mem[6], old6); end
    for (int k = 0; k < 16; k++) taps[k] = 12'h400 + 12'(k);
    run_seq(-1, 0, -1, -1, -1);
    n_checks++; if (c_done !== 35) begin n_fail++; $display("FAIL t4_reload_done: got %0d expected 35", c_done); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL t4_reload_error: got %0b expected 0", error); end
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (fir_mem[k] !== taps[k]) begin n_fail++; $display("FAIL t4_fir_tap%0d: got %0h expected %0h", k, fir_mem[k], taps[k]); end
    end
  endtask

  task automatic test_single_tap();
    @(posedge Clk); #1;
    start1 = 1'b1; s_valid1 = 1'b1; s_data1 = 12'hABC;
    @(posedge Clk); #1;
    start1 = 1'b0;
    n_checks++; if (load1 !== 1'b1) begin n_fail++; $display("FAIL t6_load_c1: got %0b expected 1", load1); end
    n_checks++; if (s_ready1 !== 1'b1) begin n_fail++; $display("FAIL t6_ready_c1: got %0b expected 1", s_ready1); end
    @(posedge Clk); #1;
    s_valid1 = 1'b0;
    n_checks++; if (load1 !== 1'b1) begin n_fail++; $display("FAIL t6_load_commit: got %0b expected 1", load1); end
    n_checks++; if (s_ready1 !== 1'b0) begin n_fail++; $display("FAIL t6_ready_commit: got %0b expected 0", s_ready1); end
    n_checks++; if (wa1 !== 8'h00) begin n_fail++; $display("FAIL t6_wa_commit: got %0h expected 0", wa1); end
    n_checks++; if (wv1 !== 12'hABC) begin n_fail++; $display("FAIL t6_wv_commit: got %0h expected abc", wv1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL t6_done_commit: got %0b expected 0", done1); end
    @(posedge Clk); #1;
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL t6_done_c3: got %0b expected 1", done1); end
    n_checks++; if (load1 !== 1'b0) begin n_fail++; $display("FAIL t6_load_c3: got %0b expected 0", load1); end
    n_checks++; if (ra1 !== 8'h00) begin n_fail++; $display("FAIL t6_read_addr: got %0h expected 0", ra1); end
    @(posedge Clk); #1;
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL t6_done_c4: got %0b expected 0", done1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL t6_busy_c4: got %0b expected 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_corrupt();
    test_start_ignored();
    test_abort();
    test_single_tap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
